mux_2to1_stream_arb: RTL

- Streaming 2:1 multiplexer: the merge counterpart of the 1:2 demultiplexer. It combines two valid/ready source channels onto one output channel.
- Each output beat is tagged with m_sel, the index of the source channel the beat came from, so a downstream 1:2 demux can route it back.
- Arbitration is round-robin with a bounded burst length per owner.
- The output is registered, giving 1-cycle latency and full throughput of one beat per cycle.

---
 rtl/mux_stream_pkg.sv | 19 +
 rtl/rr_arb_2.sv | 92 +++++++++
 rtl/mux_2to1_stream_arb.sv | 77 +++++++
 3 files changed

// File: rtl/mux_stream_pkg.sv
// Shared types and constants for the 2:1 streaming merge and its round-robin arbiter.
// The arbiter state, channel select encodings and the burst-counter width helper live here.
package mux_stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam logic SEL_CH0 = 1'b0;
    localparam logic SEL_CH1 = 1'b1;

    // Counter must be able to hold the value MAX_BURST itself.
    function automatic int cnt_width(input int max_burst);
        return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/rr_arb_2.sv
// Two-way round-robin arbiter with a bounded burst per owner.
// Grant is combinational from the valids; state, burst count and last grant advance only when load_en is high.
module rr_arb_2
    import mux_stream_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valids,
    input  logic       load_en,
    output logic       gnt,
    output logic       gnt_vld
);

    localparam int              CW      = cnt_width(MAX_BURST);
    localparam logic [CW-1:0]   CNT_MAX = CW'(MAX_BURST);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);

    arb_state_t     state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic           last_reg, last_next;
    logic           owner;
    logic           renew;

    always_comb begin
        gnt     = SEL_CH0;
        gnt_vld = 1'b0;
        renew   = 1'b0;
        owner   = (state_reg == OWN1) ? SEL_CH1 : SEL_CH0;
        case (state_reg)
            IDLE: begin
                if (valids[0] && valids[1]) begin
                    gnt     = ~last_reg;
                    gnt_vld = 1'b1;
                end else if (valids[0]) begin
                    gnt     = SEL_CH0;
                    gnt_vld = 1'b1;
                end else if (valids[1]) begin
                    gnt     = SEL_CH1;
                    gnt_vld = 1'b1;
                end
            end
            default: begin
                if (valids[owner] && (cnt_reg < CNT_MAX)) begin
                    gnt     = owner;
                    gnt_vld = 1'b1;
                end else if (valids[~owner]) begin
                    gnt     = ~owner;
                    gnt_vld = 1'b1;
                end else if (valids[owner]) begin
                    // Nobody else is waiting, so the owner starts a fresh burst.
                    gnt     = owner;
                    gnt_vld = 1'b1;
                    renew   = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        last_next  = last_reg;
        if (load_en) begin
            if (gnt_vld) begin
                state_next = gnt ? OWN1 : OWN0;
                last_next  = gnt;
                if ((state_reg != IDLE) && (gnt == owner) && !renew)
                    cnt_next = cnt_reg + CNT_ONE;
                else
                    cnt_next = CNT_ONE;
            end else begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            last_reg  <= SEL_CH1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            last_reg  <= last_next;
        end
    end

endmodule

// File: rtl/mux_2to1_stream_arb.sv
// Streaming 2:1 merge: round-robin arbitrated inputs feed a registered output slot tagged with the source index.
// The slot reloads whenever it is empty or being drained, so back-to-back beats flow without bubbles.
module mux_2to1_stream_arb
    import mux_stream_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s0_valid,
    input  logic [WIDTH-1:0] s0_data,
    output logic             s0_ready,
    input  logic             s1_valid,
    input  logic [WIDTH-1:0] s1_data,
    output logic             s1_ready,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_sel,
    input  logic             m_ready
);

    logic             m_valid_reg;
    logic [WIDTH-1:0] m_data_reg;
    logic             m_sel_reg;
    logic             load_en;
    logic             gnt;
    logic             gnt_vld;
    logic [1:0]       valids;
    logic [1:0]       ready;
    logic             take;
    logic [WIDTH-1:0] sel_data;

    assign load_en = !m_valid_reg || m_ready;
    assign valids  = {s1_valid, s0_valid};

    rr_arb_2 #(
        .MAX_BURST (MAX_BURST)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .valids  (valids),
        .load_en (load_en),
        .gnt     (gnt),
        .gnt_vld (gnt_vld)
    );

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign ready[gi] = !rst && load_en && gnt_vld && (gnt == 1'(gi)) && valids[gi];
        end
    endgenerate

    assign s0_ready = ready[0];
    assign s1_ready = ready[1];
    assign take     = |ready;
    assign sel_data = gnt ? s1_data : s0_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
            m_sel_reg   <= SEL_CH0;
        end else if (load_en) begin
            m_valid_reg <= take;
            if (take) begin
                m_data_reg <= sel_data;
                m_sel_reg  <= gnt;
            end
        end
    end

    assign m_valid = m_valid_reg;
    assign m_data  = m_data_reg;
    assign m_sel   = m_sel_reg;

endmodule
